// File: rtl/ifmem_bus_arbiter.sv
// Shares one variable-latency memory bus between instruction fetch and MEM-stage access.
// Build option BUS_TIMEOUT_EN adds a per-transfer ack timeout and the bus_err_o port.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   S_IDLE     | bus free; MEM request wins, else an unflushed fetch starts
//   S_IF_BUSY  | fetch on the bus, waiting for bus_ack_i
//   S_MEM_BUSY | data load/store on the bus, waiting for bus_ack_i

module ifmem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              stallreq_if_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              stallreq_mem_o,
  input  logic              flush_i,
  output logic              bus_cyc_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i
`ifdef BUS_TIMEOUT_EN
  ,
  output logic              bus_err_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_IF_BUSY, S_MEM_BUSY} state_t;

  state_t             r_state;
  logic               r_drop;
  logic               r_bus_cyc;
  logic               r_bus_we;
  logic [ADDR_W-1:0]  r_bus_addr;
  logic [3:0]         r_bus_sel;
  logic [DATA_W-1:0]  r_bus_wdata;
  logic [DATA_W-1:0]  r_if_rdata;
  logic [DATA_W-1:0]  r_mem_rdata;

  logic               w_busy;
  logic               w_tmo;
  logic               w_done;
  logic               w_if_done;
  logic               w_mem_done;
  logic               w_if_drop;
  logic [DATA_W-1:0]  w_xfer_data;

  generate
    if (TIMEOUT < 1) begin : g_bad_timeout
      $error("ifmem_bus_arbiter: TIMEOUT must be at least 1");
    end
  endgenerate

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_tmo_cnt;

  // Count starts at 0 in the first BUSY cycle, so the TIMEOUT-th ack-less cycle is the forced one.
  assign w_tmo     = w_busy && !bus_ack_i && (r_tmo_cnt == CNT_LAST);
  assign bus_err_o = w_tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (!w_busy) begin
      r_tmo_cnt <= '0;
    end else if (!bus_ack_i && !w_tmo) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign w_busy      = (r_state == S_IF_BUSY) || (r_state == S_MEM_BUSY);
  assign w_done      = w_busy && (bus_ack_i || w_tmo);
  assign w_xfer_data = bus_ack_i ? bus_rdata_i : '0;
  assign w_if_done   = (r_state == S_IF_BUSY) && w_done;
  assign w_mem_done  = (r_state == S_MEM_BUSY) && w_done;
  // A flush arriving in the ack cycle itself also kills the fetch result.
  assign w_if_drop   = r_drop || flush_i;

  assign if_rdata_o     = (w_if_done && !w_if_drop) ? w_xfer_data : r_if_rdata;
  assign mem_rdata_o    = (w_mem_done && !r_bus_we) ? w_xfer_data : r_mem_rdata;
  assign stallreq_mem_o = mem_req_i && !w_mem_done;
  assign stallreq_if_o  = if_req_i && !flush_i && !(w_if_done && !w_if_drop);

  assign bus_cyc_o   = r_bus_cyc;
  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_sel_o   = r_bus_sel;
  assign bus_wdata_o = r_bus_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_drop      <= 1'b0;
      r_bus_cyc   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_sel   <= '0;
      r_bus_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_drop <= 1'b0;
          if (mem_req_i) begin
            r_state     <= S_MEM_BUSY;
            r_bus_cyc   <= 1'b1;
            r_bus_we    <= mem_we_i;
            r_bus_addr  <= mem_addr_i;
            r_bus_sel   <= mem_sel_i;
            r_bus_wdata <= mem_wdata_i;
          end else if (if_req_i && !flush_i) begin
            r_state     <= S_IF_BUSY;
            r_bus_cyc   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= if_addr_i;
            r_bus_sel   <= 4'hF;
            r_bus_wdata <= '0;
          end
        end
        S_IF_BUSY: begin
          if (w_done) begin
            r_state   <= S_IDLE;
            r_bus_cyc <= 1'b0;
            r_drop    <= 1'b0;
            if (!w_if_drop) begin
              r_if_rdata <= w_xfer_data;
            end
          end else if (flush_i) begin
            r_drop <= 1'b1;
          end
        end
        S_MEM_BUSY: begin
          if (w_done) begin
            r_state   <= S_IDLE;
            r_bus_cyc <= 1'b0;
            if (!r_bus_we) begin
              r_mem_rdata <= w_xfer_data;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_bus_cyc <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifmem_bus_arbiter.sv
// Directed bench for ifmem_bus_arbiter: stimulus pushes expected transfers, a monitor
// checks each one at its ack cycle; a few state checks run inline.

module tb_ifmem_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        stallreq_if_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        stallreq_mem_o;
  logic        flush_i;
  logic        bus_cyc_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  ifmem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_rdata_o     (if_rdata_o),
    .stallreq_if_o  (stallreq_if_o),
    .mem_req_i      (mem_req_i),
    .mem_we_i       (mem_we_i),
    .mem_addr_i     (mem_addr_i),
    .mem_sel_i      (mem_sel_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_rdata_o    (mem_rdata_o),
    .stallreq_mem_o (stallreq_mem_o),
    .flush_i        (flush_i),
    .bus_cyc_o      (bus_cyc_o),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_sel_o      (bus_sel_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata_i),
    .bus_ack_i      (bus_ack_i)
  );

  typedef struct {
    logic        is_mem;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] if_rd;
    logic [31:0] mem_rd;
    logic        st_if;
    logic        st_mem;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc_cnt = 0;
  bit   after_ack = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_mem, input logic [31:0] addr, input logic we,
                      input logic [3:0] sel, input logic [31:0] wdata,
                      input logic [31:0] if_rd, input logic [31:0] mem_rd,
                      input logic st_if, input logic st_mem, input int len);
    exp_t e;
    e.is_mem = is_mem; e.addr = addr; e.we = we; e.sel = sel; e.wdata = wdata;
    e.if_rd = if_rd; e.mem_rd = mem_rd; e.st_if = st_if; e.st_mem = st_mem; e.len = len;
    sb.push_back(e);
  endtask

  // Request must already be driven with the DUT idle; ack arrives in busy cycle 'lat'.
  task automatic finish_xfer(input int lat, input logic [31:0] d);
    tick();
    repeat (lat - 1) tick();
    bus_ack_i   = 1'b1;
    bus_rdata_i = d;
    tick();
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cyc_cnt   = 0;
      after_ack = 0;
    end else begin
      if (after_ack) begin
        check("idle_gap_cyc", {31'd0, bus_cyc_o}, 32'd0);
        after_ack = 0;
      end
      if (bus_cyc_o) cyc_cnt++;
      if (bus_cyc_o && bus_ack_i) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("bus_addr", bus_addr_o, e.addr);
          check("bus_we", {31'd0, bus_we_o}, {31'd0, e.we});
          check("bus_sel", {28'd0, bus_sel_o}, {28'd0, e.sel});
          if (e.is_mem) check("bus_wdata", bus_wdata_o, e.wdata);
          check("if_rdata", if_rdata_o, e.if_rd);
          check("mem_rdata", mem_rdata_o, e.mem_rd);
          check("stall_if", {31'd0, stallreq_if_o}, {31'd0, e.st_if});
          check("stall_mem", {31'd0, stallreq_mem_o}, {31'd0, e.st_mem});
          check("cyc_len", 32'(cyc_cnt), 32'(e.len));
        end
        cyc_cnt   = 0;
        after_ack = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    mem_addr_i = '0; mem_sel_i = '0; mem_wdata_i = '0; flush_i = 1'b0;
    bus_rdata_i = '0; bus_ack_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_cyc", {31'd0, bus_cyc_o}, 32'd0);
    check("rst_we", {31'd0, bus_we_o}, 32'd0);
    check("rst_sel", {28'd0, bus_sel_o}, 32'd0);
    check("rst_addr", bus_addr_o, 32'd0);
    check("rst_wdata", bus_wdata_o, 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'd0);
    check("rst_mem_rdata", mem_rdata_o, 32'd0);

    // ack while idle is ignored
    bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFEBABE;
    @(negedge clk);
    check("idle_ack_if_rdata", if_rdata_o, 32'd0);
    check("idle_ack_mem_rdata", mem_rdata_o, 32'd0);
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    @(negedge clk);
    check("idle_ack_cyc", {31'd0, bus_cyc_o}, 32'd0);
    check("idle_ack_if_held", if_rdata_o, 32'd0);

    // single fetch, 3-cycle latency
    if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
    push(0, 32'h10, 0, 4'hF, 0, 32'h3C010001, 32'd0, 0, 0, 3);
    finish_xfer(3, 32'h3C010001);
    if_req_i = 1'b0;

    // simultaneous: MEM load first, idle cycle, then fetch with minimum latency
    if_req_i = 1'b1; if_addr_i = 32'h0000_0020;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0100; mem_sel_i = 4'hF;
    push(1, 32'h100, 0, 4'hF, 0, 32'h3C010001, 32'hA5A50001, 1, 0, 2);
    finish_xfer(2, 32'hA5A50001);
    mem_req_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0;
    @(negedge clk);
    check("stall_if_gap", {31'd0, stallreq_if_o}, 32'd1);
    push(0, 32'h20, 0, 4'hF, 0, 32'h27BDFFE8, 32'hA5A50001, 0, 0, 1);
    finish_xfer(1, 32'h27BDFFE8);
    if_req_i = 1'b0;

    // store with flush held: flush must not disturb the MEM access
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_0200;
    mem_sel_i = 4'b0011; mem_wdata_i = 32'hDEADBEEF; flush_i = 1'b1;
    push(1, 32'h200, 1, 4'b0011, 32'hDEADBEEF, 32'h27BDFFE8, 32'hA5A50001, 0, 0, 4);
    finish_xfer(4, 32'hA5A50001);
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0;
    mem_wdata_i = '0; flush_i = 1'b0; bus_rdata_i = 32'h12345678;
    @(negedge clk);
    check("store_mem_rdata_held", mem_rdata_o, 32'hA5A50001);
    bus_rdata_i = '0;

    // flush mid-fetch: result dropped, stall kept, then refetch from idle
    if_req_i = 1'b1; if_addr_i = 32'h0000_0030;
    push(0, 32'h30, 0, 4'hF, 0, 32'h27BDFFE8, 32'hA5A50001, 1, 0, 3);
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    check("stall_if_flush", {31'd0, stallreq_if_o}, 32'd0);
    tick();
    flush_i = 1'b0;
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    @(negedge clk);
    check("flush_if_rdata_held", if_rdata_o, 32'h27BDFFE8);
    push(0, 32'h30, 0, 4'hF, 0, 32'h8FA40000, 32'hA5A50001, 0, 0, 2);
    finish_xfer(2, 32'h8FA40000);
    if_req_i = 1'b0;

    // flush in idle inhibits a fetch start
    if_req_i = 1'b1; if_addr_i = 32'h0000_0040; flush_i = 1'b1;
    tick();
    @(negedge clk);
    check("flush_idle_no_cyc", {31'd0, bus_cyc_o}, 32'd0);
    check("flush_idle_stall_if", {31'd0, stallreq_if_o}, 32'd0);
    if_req_i = 1'b0; flush_i = 1'b0;

    // reset mid-MEM_BUSY
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0300; mem_sel_i = 4'hF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_req_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0;
    @(negedge clk);
    check("rst_mid_cyc", {31'd0, bus_cyc_o}, 32'd0);
    check("rst_mid_if_rdata", if_rdata_o, 32'd0);
    check("rst_mid_mem_rdata", mem_rdata_o, 32'd0);
    check("rst_mid_stall_mem", {31'd0, stallreq_mem_o}, 32'd0);
    if_req_i = 1'b1; if_addr_i = 32'h0000_0050;
    push(0, 32'h50, 0, 4'hF, 0, 32'h11112222, 32'd0, 0, 0, 1);
    finish_xfer(1, 32'h11112222);
    if_req_i = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
